// File: rtl/seq_muldiv_unit.sv
// Sequential multiply/divide unit: one radix-2 step per clock, shift-add multiply, restoring divide.
// Latency: Ready in cycle WIDTH+1 after the start edge (WIDTH+2 when signed support is built in), cycle 1 for divide-by-zero.
// Backpressure: Run/Ready handshake; Ready holds while Run stays high, and a new start needs Run low for one cycle.
//
// Optional feature macro: SEQ_MULDIV_SIGNED_EN
//   undefined : unsigned operands only, no FIX state, no sign logic.
//   defined   : two's complement operands; magnitudes are iterated and a
//               one-cycle FIX state applies the result signs.
//
// Ports:
//   clk      rising-edge clock
//   Reset    synchronous active-high reset
//   Run      start request (level, sampled only in IDLE)
//   Mode     0 = multiply, 1 = divide (latched at start)
//   A, B     multiplicand/dividend, multiplier/divisor (latched at start)
//   Busy     operation in progress
//   Ready    result valid
//   Hi, Lo   multiply: product upper/lower half; divide: remainder/quotient
//   DivZero  divide with B == 0, valid with Ready

module seq_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Ready,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
`ifdef SEQ_MULDIV_SIGNED_EN
    localparam logic [1:0] S_FIX  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    // Multiplicand when multiplying, divisor when dividing. The other
    // operand lives in Lo and is consumed/replaced bit by bit.
    logic [WIDTH-1:0] opnd;

`ifdef SEQ_MULDIV_SIGNED_EN
    logic             neg_main;   // negate product / quotient
    logic             neg_rem;    // remainder follows the dividend sign
`endif

    // ------------------------------------------------------------------
    // Operand preparation at start
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
`ifdef SEQ_MULDIV_SIGNED_EN
        // The magnitude of the most negative value is itself when read as
        // unsigned, which is exactly what the datapath needs.
        a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
        b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;
`else
        a_mag = A;
        b_mag = B;
`endif
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;

    always_comb begin
        mul_sum  = {1'b0, Hi} + (Lo[0] ? {1'b0, opnd} : '0);
        // Partial remainder after the left shift is {Hi, Lo[MSB]}, which
        // needs WIDTH+1 bits. If the bit shifted out of Hi is set, the
        // remainder already exceeds any divisor and the difference fits in
        // WIDTH bits; otherwise the difference sign bit decides.
        div_diff = {Hi, Lo[WIDTH-1]} - {1'b0, opnd};
        div_ge   = Hi[WIDTH-1] | ~div_diff[WIDTH];

        it_hi = Hi;
        it_lo = Lo;
        if (mode_q) begin
            it_hi = div_ge ? div_diff[WIDTH-1:0] : {Hi[WIDTH-2:0], Lo[WIDTH-1]};
            it_lo = {Lo[WIDTH-2:0], div_ge};
        end else begin
            // Shift {carry, sum, Lo} right by one.
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], Lo[WIDTH-1:1]};
        end
    end

`ifdef SEQ_MULDIV_SIGNED_EN
    // ------------------------------------------------------------------
    // Sign fix-up applied in the FIX cycle
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod_fix = neg_main ? (~{Hi, Lo} + 1'b1) : {Hi, Lo};
        if (mode_q) begin
            fix_lo = neg_main ? (~Lo + 1'b1) : Lo;
            fix_hi = neg_rem  ? (~Hi + 1'b1) : Hi;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            mode_q   <= 1'b0;
            opnd     <= '0;
            Busy     <= 1'b0;
            Ready    <= 1'b0;
            DivZero  <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
`ifdef SEQ_MULDIV_SIGNED_EN
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Run) begin
                        mode_q <= Mode;
                        cnt    <= '0;
                        if (Mode && (B == '0)) begin
                            // Divide by zero short-circuits with the raw
                            // dividend as remainder, in either build.
                            state   <= S_DONE;
                            Ready   <= 1'b1;
                            DivZero <= 1'b1;
                            Lo      <= '1;
                            Hi      <= A;
                        end else begin
                            state   <= S_ITER;
                            Busy    <= 1'b1;
                            DivZero <= 1'b0;
                            Hi      <= '0;
                            if (Mode) begin
                                Lo   <= a_mag;
                                opnd <= b_mag;
                            end else begin
                                Lo   <= b_mag;
                                opnd <= a_mag;
                            end
`ifdef SEQ_MULDIV_SIGNED_EN
                            neg_main <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_rem  <= A[WIDTH-1];
`endif
                        end
                    end
                end

                S_ITER: begin
                    Hi  <= it_hi;
                    Lo  <= it_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
`ifdef SEQ_MULDIV_SIGNED_EN
                        state <= S_FIX;
`else
                        state <= S_DONE;
                        Busy  <= 1'b0;
                        Ready <= 1'b1;
`endif
                    end
                end

`ifdef SEQ_MULDIV_SIGNED_EN
                S_FIX: begin
                    Hi    <= fix_hi;
                    Lo    <= fix_lo;
                    state <= S_DONE;
                    Busy  <= 1'b0;
                    Ready <= 1'b1;
                end
`endif

                S_DONE: begin
                    // Hold the result until Run drops; this forces at least
                    // one low cycle of Run between operations.
                    if (!Run) begin
                        state <= S_IDLE;
                        Ready <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    Ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
